// File: rtl/uart_pkg.sv
// Shared definitions for the UART command decoder: FSM state encoding,
// frame defaults and the length-validity helper.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_HUNT    = 3'd0,
    ST_OP      = 3'd1,
    ST_LEN     = 3'd2,
    ST_PAYLOAD = 3'd3,
    ST_CHK     = 3'd4,
    ST_HOLD    = 3'd5
  } state_e;

  localparam logic [7:0] SYNC_BYTE_DEF      = 8'hA5;
  localparam int         MAX_LEN_DEF        = 8;
  localparam int         TIMEOUT_CYCLES_DEF = 4096;

  // Judged on the full received byte, before it is narrowed to the 4-bit length.
  function automatic logic len_invalid(input logic [7:0] len, input int max_len);
    return (len == 8'd0) || (int'(len) > max_len);
  endfunction

endpackage

// File: rtl/uart_cmd_decoder_if.sv
// Byte-stream input and command/error output bundle of the UART command decoder.
// master = decoder side, slave = byte source / command consumer side.
interface uart_cmd_decoder_if
  import uart_pkg::*;
#(
  parameter int MAX_LEN = MAX_LEN_DEF
);
  logic                 data_ready;
  logic [7:0]           data_in;
  logic                 cmd_ready;
  logic                 cmd_valid;
  logic [7:0]           cmd_op;
  logic [3:0]           cmd_len;
  logic [MAX_LEN*8-1:0] cmd_payload;
  logic                 err_chk;
  logic                 err_len;
  logic                 err_timeout;
  logic                 err_overrun;
  logic                 busy;

  modport master (
    input  data_ready, data_in, cmd_ready,
    output cmd_valid, cmd_op, cmd_len, cmd_payload,
    output err_chk, err_len, err_timeout, err_overrun, busy
  );

  modport slave (
    output data_ready, data_in, cmd_ready,
    input  cmd_valid, cmd_op, cmd_len, cmd_payload,
    input  err_chk, err_len, err_timeout, err_overrun, busy
  );
endinterface

// File: rtl/uart_timeout_counter.sv
// Watchdog counter: counts enabled cycles since the last clear and flags the
// cycle in which LIMIT cycles have elapsed; reusable as a receiver idle watchdog.
module uart_timeout_counter #(
  parameter int LIMIT = 4096,
  parameter bit DOWN  = 1'b0,
  parameter int W     = (LIMIT > 1) ? $clog2(LIMIT) : 1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);
  localparam logic [W-1:0] LAST  = W'(LIMIT - 1);
  localparam logic [W-1:0] ONE   = W'(1);
  localparam logic [W-1:0] START = DOWN ? LAST : '0;
  localparam logic [W-1:0] TERM  = DOWN ? '0 : LAST;

  logic [W-1:0] cnt_q, cnt_d, step;

  generate
    if (DOWN) begin : g_down
      assign step = cnt_q - ONE;
    end else begin : g_up
      assign step = cnt_q + ONE;
    end
  endgenerate

  // A clear in the terminal cycle suppresses the expiry.
  assign expire_o = en_i && !clr_i && (cnt_q == TERM);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = START;
    end else if (en_i) begin
      cnt_d = (cnt_q == TERM) ? START : step;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= START;
    else       cnt_q <= cnt_d;
  end
endmodule

// File: rtl/uart_cmd_decoder.sv
// Frames UART bytes (SYNC, OP, LEN, payload, XOR CHK) into commands presented
// over valid/ready, with pulsed checksum, length, timeout and overrun errors.
module uart_cmd_decoder
  import uart_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEF,
  parameter int         MAX_LEN        = MAX_LEN_DEF,
  parameter int         TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic               clk_i,
  input  logic               rst_i,
  uart_cmd_decoder_if.master bus_if
);
  localparam int PW = MAX_LEN * 8;

  state_e        state_q, state_d;
  logic [7:0]    op_q, op_d, chk_q, chk_d;
  logic [3:0]    len_q, len_d, cnt_q, cnt_d;
  logic [PW-1:0] pay_q, pay_d;
  logic          cmd_valid_q, cmd_valid_d;
  logic [7:0]    cmd_op_q, cmd_op_d;
  logic [3:0]    cmd_len_q, cmd_len_d;
  logic [PW-1:0] cmd_payload_q, cmd_payload_d;
  logic          err_chk_q, err_chk_d, err_len_q, err_len_d;
  logic          err_timeout_q, err_timeout_d, err_overrun_q, err_overrun_d;
  logic          busy_q, busy_d;

  logic               pay_clr, pay_wr;
  logic [MAX_LEN-1:0] slot_we;
  logic               tmo_en, tmo_clr, tmo_expire;
  logic               dr;
  logic [7:0]         din;

  assign dr  = bus_if.data_ready;
  assign din = bus_if.data_in;

  // The watchdog only runs while a frame is partially received.
  assign tmo_en  = (state_q != ST_HUNT) && (state_q != ST_HOLD);
  assign tmo_clr = dr || (state_q == ST_HUNT);

  uart_timeout_counter #(.LIMIT(TIMEOUT_CYCLES)) u_tmo (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clr_i    (tmo_clr),
    .en_i     (tmo_en),
    .expire_o (tmo_expire)
  );

  for (genvar gi = 0; gi < MAX_LEN; gi++) begin : g_slot
    assign slot_we[gi] = pay_wr && (cnt_q == 4'(gi));
  end

  always_comb begin
    pay_d = pay_q;
    if (pay_clr) pay_d = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if (slot_we[i]) pay_d[i*8 +: 8] = din;
    end
  end

  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    len_d         = len_q;
    chk_d         = chk_q;
    cnt_d         = cnt_q;
    pay_clr       = 1'b0;
    pay_wr        = 1'b0;
    cmd_valid_d   = cmd_valid_q;
    cmd_op_d      = cmd_op_q;
    cmd_len_d     = cmd_len_q;
    cmd_payload_d = cmd_payload_q;
    err_chk_d     = 1'b0;
    err_len_d     = 1'b0;
    err_timeout_d = 1'b0;
    err_overrun_d = 1'b0;

    case (state_q)
      ST_HUNT: begin
        if (dr && din == SYNC_BYTE) begin
          pay_clr = 1'b1;
          chk_d   = 8'd0;
          state_d = ST_OP;
        end
      end
      ST_OP: begin
        if (dr) begin
          op_d    = din;
          chk_d   = din;
          state_d = ST_LEN;
        end
      end
      ST_LEN: begin
        if (dr) begin
          if (len_invalid(din, MAX_LEN)) begin
            err_len_d = 1'b1;
            state_d   = ST_HUNT;
          end else begin
            len_d   = din[3:0];
            chk_d   = chk_q ^ din;
            cnt_d   = 4'd0;
            state_d = ST_PAYLOAD;
          end
        end
      end
      ST_PAYLOAD: begin
        if (dr) begin
          pay_wr = 1'b1;
          chk_d  = chk_q ^ din;
          cnt_d  = cnt_q + 4'd1;
          if (cnt_q == len_q - 4'd1) state_d = ST_CHK;
        end
      end
      ST_CHK: begin
        if (dr) begin
          if (din == chk_q) begin
            cmd_op_d      = op_q;
            cmd_len_d     = len_q;
            cmd_payload_d = pay_q;
            cmd_valid_d   = 1'b1;
            state_d       = ST_HOLD;
          end else begin
            err_chk_d = 1'b1;
            state_d   = ST_HUNT;
          end
        end
      end
      ST_HOLD: begin
        // Bytes arriving while a command is held are dropped, SYNC included.
        if (dr) err_overrun_d = 1'b1;
        if (bus_if.cmd_ready) begin
          cmd_valid_d = 1'b0;
          state_d     = ST_HUNT;
        end
      end
      default: state_d = ST_HUNT;
    endcase

    // Expiry is only signalled without a byte in the same cycle, so it never
    // collides with the byte-driven transitions above.
    if (tmo_expire) begin
      err_timeout_d = 1'b1;
      state_d       = ST_HUNT;
    end
  end

  assign busy_d = (state_d != ST_HUNT);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= ST_HUNT;
      op_q          <= '0;
      len_q         <= '0;
      chk_q         <= '0;
      cnt_q         <= '0;
      pay_q         <= '0;
      cmd_valid_q   <= 1'b0;
      cmd_op_q      <= '0;
      cmd_len_q     <= '0;
      cmd_payload_q <= '0;
      err_chk_q     <= 1'b0;
      err_len_q     <= 1'b0;
      err_timeout_q <= 1'b0;
      err_overrun_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      len_q         <= len_d;
      chk_q         <= chk_d;
      cnt_q         <= cnt_d;
      pay_q         <= pay_d;
      cmd_valid_q   <= cmd_valid_d;
      cmd_op_q      <= cmd_op_d;
      cmd_len_q     <= cmd_len_d;
      cmd_payload_q <= cmd_payload_d;
      err_chk_q     <= err_chk_d;
      err_len_q     <= err_len_d;
      err_timeout_q <= err_timeout_d;
      err_overrun_q <= err_overrun_d;
      busy_q        <= busy_d;
    end
  end

  assign bus_if.cmd_valid   = cmd_valid_q;
  assign bus_if.cmd_op      = cmd_op_q;
  assign bus_if.cmd_len     = cmd_len_q;
  assign bus_if.cmd_payload = cmd_payload_q;
  assign bus_if.err_chk     = err_chk_q;
  assign bus_if.err_len     = err_len_q;
  assign bus_if.err_timeout = err_timeout_q;
  assign bus_if.err_overrun = err_overrun_q;
  assign bus_if.busy        = busy_q;
endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Scoreboard bench: stimulus pushes expected events computed from frame
// contents; an independent monitor pops and compares every observed event.
module tb_uart_cmd_decoder;
  import uart_pkg::*;

  localparam int ML = 8;
  localparam int T  = 4096;
  localparam int PW = ML * 8;
  localparam int K_CMD = 0, K_CHK = 1, K_LEN = 2, K_TO = 3, K_OVR = 4;

  typedef logic [7:0] bq_t[$];
  typedef struct {
    int            kind;
    logic [7:0]    op;
    logic [3:0]    len;
    logic [PW-1:0] pay;
  } exp_t;

  exp_t exp_q[$];
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   transfers = 0;
  int   n_timeouts = 0;

  uart_cmd_decoder_if #(.MAX_LEN(ML)) bus_if ();

  uart_cmd_decoder #(.SYNC_BYTE(8'hA5), .MAX_LEN(ML), .TIMEOUT_CYCLES(T)) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .bus_if (bus_if)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [PW-1:0] act, input logic [PW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  function automatic string kname(input int k);
    case (k)
      K_CMD:   return "CMD";
      K_CHK:   return "ERR_CHK";
      K_LEN:   return "ERR_LEN";
      K_TO:    return "ERR_TIMEOUT";
      default: return "ERR_OVERRUN";
    endcase
  endfunction

  // ---------------- reference model (frame level) ----------------
  function automatic bq_t make_frame(input logic [7:0] op, input bq_t pl, input logic [7:0] chk_flip);
    bq_t f;
    logic [7:0] c;
    c = op ^ 8'(pl.size());
    foreach (pl[i]) c ^= pl[i];
    f.push_back(8'hA5);
    f.push_back(op);
    f.push_back(8'(pl.size()));
    foreach (pl[i]) f.push_back(pl[i]);
    f.push_back(c ^ chk_flip);
    return f;
  endfunction

  function automatic exp_t ref_cmd(input logic [7:0] op, input bq_t pl);
    exp_t e;
    e.kind = K_CMD;
    e.op   = op;
    e.len  = 4'(pl.size());
    e.pay  = '0;
    foreach (pl[i]) e.pay[i*8 +: 8] = pl[i];
    return e;
  endfunction

  function automatic exp_t ref_err(input int k);
    exp_t e;
    e.kind = k;
    e.op   = '0;
    e.len  = '0;
    e.pay  = '0;
    return e;
  endfunction

  function automatic bq_t rand_payload(input int n);
    bq_t q;
    for (int i = 0; i < n; i++) q.push_back(8'($urandom_range(0, 255)));
    return q;
  endfunction

  // ---------------- monitor / scoreboard ----------------
  logic          prev_valid = 1'b0;
  logic [3:0]    prev_errs = '0;
  logic [7:0]    prev_op;
  logic [3:0]    prev_len;
  logic [PW-1:0] prev_pay;
  logic [3:0]    m_errs;
  int            m_kind;

  task automatic observe(input int kind);
    exp_t e;
    $display("%0t: event %s op=%0h len=%0d pay=%0h", $time, kname(kind),
             bus_if.cmd_op, bus_if.cmd_len, bus_if.cmd_payload);
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_event: got %s, expected none", kname(kind));
    end else begin
      e = exp_q.pop_front();
      check("event_kind", PW'(kind), PW'(e.kind));
      if (kind == K_CMD && e.kind == K_CMD) begin
        check("cmd_op", PW'(bus_if.cmd_op), PW'(e.op));
        check("cmd_len", PW'(bus_if.cmd_len), PW'(e.len));
        check("cmd_payload", bus_if.cmd_payload, e.pay);
      end
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (rst) begin
      prev_valid = 1'b0;
      prev_errs  = '0;
    end else begin
      m_errs = {bus_if.err_overrun, bus_if.err_timeout, bus_if.err_len, bus_if.err_chk};
      if (prev_valid && bus_if.cmd_ready) begin
        transfers++;
        check("single_transfer", PW'(bus_if.cmd_valid), PW'(0));
      end else if (prev_valid) begin
        check("valid_held", PW'(bus_if.cmd_valid), PW'(1));
        check("hold_op", PW'(bus_if.cmd_op), PW'(prev_op));
        check("hold_len", PW'(bus_if.cmd_len), PW'(prev_len));
        check("hold_payload", bus_if.cmd_payload, prev_pay);
      end
      if (bus_if.cmd_valid && !prev_valid) observe(K_CMD);
      if (m_errs != 4'd0) begin
        check("err_onehot_single_cycle",
              PW'({$countones(m_errs) == 1, (m_errs & prev_errs) == 4'd0}), PW'(2'b11));
        m_kind = m_errs[0] ? K_CHK : m_errs[1] ? K_LEN : m_errs[2] ? K_TO : K_OVR;
        observe(m_kind);
      end
      prev_valid = bus_if.cmd_valid;
      prev_errs  = m_errs;
      prev_op    = bus_if.cmd_op;
      prev_len   = bus_if.cmd_len;
      prev_pay   = bus_if.cmd_payload;
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus_if.data_ready = 1'b1;
    bus_if.data_in    = b;
    @(negedge clk);
    bus_if.data_ready = 1'b0;
  endtask

  task automatic send_bytes(input bq_t q, input int maxgap);
    foreach (q[i]) begin
      if (i > 0) idle($urandom_range(0, maxgap));
      send_byte(q[i]);
    end
  endtask

  task automatic run_good(input logic [7:0] op, input bq_t pl, input bit hold, input bit inject);
    int t0;
    int n;
    exp_q.push_back(ref_cmd(op, pl));
    if (hold) bus_if.cmd_ready = 1'b0;
    send_bytes(make_frame(op, pl, 8'h00), 3);
    check("cmd_valid_latency", PW'(bus_if.cmd_valid), PW'(1));
    if (hold) begin
      idle($urandom_range(1, 4));
      if (inject) begin
        exp_q.push_back(ref_err(K_OVR));
        send_byte(8'hA5);
        check("overrun_pulse", PW'(bus_if.err_overrun), PW'(1));
      end
      idle(2);
      t0 = transfers;
      bus_if.cmd_ready = 1'b1;
      n = 0;
      while (bus_if.cmd_valid && n < 10) begin
        @(negedge clk);
        n++;
      end
      check("hold_release", PW'(bus_if.cmd_valid), PW'(0));
      check("transfer_count", PW'(transfers), PW'(t0 + 1));
    end
    idle(3);
    check("busy_after_frame", PW'(bus_if.busy), PW'(0));
  endtask

  task automatic run_badchk(input logic [7:0] op, input bq_t pl, input logic [7:0] flip);
    exp_q.push_back(ref_err(K_CHK));
    send_bytes(make_frame(op, pl, flip), 3);
    check("err_chk_latency", PW'(bus_if.err_chk), PW'(1));
    check("no_valid_on_err", PW'(bus_if.cmd_valid), PW'(0));
    idle(3);
  endtask

  task automatic run_badlen(input logic [7:0] op, input logic [7:0] len, input int trail);
    logic [7:0] b;
    exp_q.push_back(ref_err(K_LEN));
    send_bytes({8'hA5, op, len}, 2);
    check("err_len_latency", PW'(bus_if.err_len), PW'(1));
    for (int i = 0; i < trail; i++) begin
      b = 8'($urandom_range(0, 255));
      if (b == 8'hA5) b = 8'h01;
      send_byte(b);
    end
    idle(3);
    check("busy_after_badlen", PW'(bus_if.busy), PW'(0));
  endtask

  task automatic run_timeout(input bq_t pre);
    exp_q.push_back(ref_err(K_TO));
    send_bytes(pre, 2);
    idle(T - 1);
    check("no_early_timeout", PW'(bus_if.err_timeout), PW'(0));
    check("busy_before_timeout", PW'(bus_if.busy), PW'(1));
    idle(1);
    check("timeout_pulse", PW'(bus_if.err_timeout), PW'(1));
    idle(2);
    check("busy_after_timeout", PW'(bus_if.busy), PW'(0));
  endtask

  initial begin
    bq_t pl;
    bq_t full;
    int  kind;
    int  k;
    logic [7:0] b;

    bus_if.data_ready = 1'b0;
    bus_if.data_in    = 8'h00;
    bus_if.cmd_ready  = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_cmd_valid", PW'(bus_if.cmd_valid), PW'(0));
    check("reset_busy", PW'(bus_if.busy), PW'(0));
    check("reset_cmd_op", PW'(bus_if.cmd_op), PW'(0));
    check("reset_cmd_payload", bus_if.cmd_payload, PW'(0));
    check("reset_errs", PW'({bus_if.err_chk, bus_if.err_len, bus_if.err_timeout, bus_if.err_overrun}), PW'(0));
    rst = 1'b0;
    idle(2);

    // Reference frame A5 10 02 34 12 34 and its corrupted-checksum twin.
    pl = {8'h34, 8'h12};
    run_good(8'h10, pl, 1'b0, 1'b0);
    run_badchk(8'h10, pl, 8'h01);
    run_good(8'h10, pl, 1'b0, 1'b0);

    run_badlen(8'h10, 8'h09, 2);
    run_badlen(8'h10, 8'h00, 0);
    run_good(8'h5A, rand_payload(ML), 1'b0, 1'b0);
    run_good(8'hC3, rand_payload(1), 1'b0, 1'b0);

    run_timeout({8'hA5, 8'h10});

    // A byte landing exactly on the expiry cycle keeps the frame alive.
    exp_q.push_back(ref_cmd(8'h10, pl));
    send_bytes({8'hA5, 8'h10}, 0);
    idle(T - 1);
    send_bytes({8'h02, 8'h34, 8'h12, 8'h34}, 0);
    check("expiry_byte_wins", PW'(bus_if.cmd_valid), PW'(1));
    idle(3);
    check("busy_after_expiry_frame", PW'(bus_if.busy), PW'(0));

    run_good(8'h10, pl, 1'b1, 1'b1);

    // Asynchronous reset in the middle of a payload.
    send_bytes({8'hA5, 8'h10, 8'h02, 8'h34}, 0);
    check("busy_mid_payload", PW'(bus_if.busy), PW'(1));
    #2 rst = 1'b1;
    #1;
    check("async_rst_busy", PW'(bus_if.busy), PW'(0));
    check("async_rst_cmd_op", PW'(bus_if.cmd_op), PW'(0));
    check("async_rst_cmd_len", PW'(bus_if.cmd_len), PW'(0));
    check("async_rst_cmd_payload", bus_if.cmd_payload, PW'(0));
    check("async_rst_cmd_valid", PW'(bus_if.cmd_valid), PW'(0));
    @(negedge clk);
    rst = 1'b0;
    idle(1);
    run_good(8'h10, pl, 1'b0, 1'b0);

    for (int it = 0; it < 40; it++) begin
      kind = $urandom_range(0, 9);
      pl   = rand_payload($urandom_range(1, ML));
      b    = 8'($urandom_range(0, 255));
      case (kind)
        0, 1, 2, 3: run_good(b, pl, 1'b0, 1'b0);
        4: run_badchk(b, pl, 8'($urandom_range(1, 255)));
        5: run_badlen(b, ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(ML + 1, 255)),
                      $urandom_range(0, 4));
        6: begin
          for (int i = 0; i < $urandom_range(1, 6); i++) begin
            b = 8'($urandom_range(0, 255));
            if (b == 8'hA5) b = 8'h00;
            send_byte(b);
          end
          idle(2);
          check("busy_after_noise", PW'(bus_if.busy), PW'(0));
        end
        7, 8: run_good(b, pl, 1'b1, 1'($urandom_range(0, 1)));
        default: begin
          if (n_timeouts < 2) begin
            n_timeouts++;
            full = make_frame(b, pl, 8'h00);
            k = $urandom_range(0, pl.size() + 2);
            run_timeout(full[0:k]);
          end else begin
            run_good(b, pl, 1'b0, 1'b0);
          end
        end
      endcase
    end

    idle(10);
    check("scoreboard_drained", PW'(exp_q.size()), PW'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end
endmodule
